// File: rtl/niu32_io_responder.sv
// niu32_io_responder
// Memory-mapped I/O responder for the Niu32 data-memory port. Answers loads
// and stores in the window 0xFFFF0000-0xFFFF01FF, holds the HEX/LEDR/LEDG
// output latches, debounces KEY and SWITCH and records sticky key presses.
// Accesses outside the window are ignored so the data RAM can answer them.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   addr       byte address from the CPU
//   wdata      store data
//   wr_en      store request (one cycle)
//   rd_en      load request (one cycle)
//   rdata      registered load data, holds until the next in-window load
//   ack        one-cycle pulse the cycle after an in-window access
//   key_raw    board KEY, active-low, asynchronous
//   switch_raw board SWITCH, asynchronous
//   hex_out    four hex digits for the seven-segment decoders
//   ledr       red LEDs
//   ledg       green LEDs
module niu32_io_responder #(
  parameter int                   WORD_SIZE       = 32,
  parameter int                   DEBOUNCE_CYCLES = 50000,
  parameter logic [WORD_SIZE-1:0] ADDR_HEX        = 32'hFFFF0000,
  parameter logic [WORD_SIZE-1:0] ADDR_LEDR       = 32'hFFFF0020,
  parameter logic [WORD_SIZE-1:0] ADDR_LEDG       = 32'hFFFF0040,
  parameter logic [WORD_SIZE-1:0] ADDR_KEY        = 32'hFFFF0100,
  parameter logic [WORD_SIZE-1:0] ADDR_KEYEDGE    = 32'hFFFF0104,
  parameter logic [WORD_SIZE-1:0] ADDR_SWITCH     = 32'hFFFF0120
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic                 wr_en,
  input  logic                 rd_en,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 ack,
  input  logic [3:0]           key_raw,
  input  logic [9:0]           switch_raw,
  output logic [15:0]          hex_out,
  output logic [9:0]           ledr,
  output logic [7:0]           ledg
);

  // The window is the 512-byte block that contains the HEX register.
  localparam logic [WORD_SIZE-1:0] WIN_MASK = WORD_SIZE'(32'h000001FF);
  localparam logic [WORD_SIZE-1:0] WIN_BASE = ADDR_HEX & ~WIN_MASK;

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // KEY and SWITCH share one debounce array: bits [3:0] are keys (idle high),
  // bits [13:4] are switches (idle low).
  localparam int NBITS = 14;
  localparam logic [NBITS-1:0] IDLE_VAL = {10'b0, 4'b1111};

  logic [NBITS-1:0] raw_all;
  logic [NBITS-1:0] stable_all;
  logic [NBITS-1:0] adopt;

  logic [15:0]          hex_reg;
  logic [9:0]           ledr_reg;
  logic [7:0]           ledg_reg;
  logic [3:0]           keyedge_reg;
  logic [3:0]           keyedge_next;
  logic [3:0]           keyedge_clr;
  logic [3:0]           press;
  logic [WORD_SIZE-1:0] rdata_reg;
  logic                 ack_reg;
  logic [WORD_SIZE-1:0] rd_value;

  logic in_win;
  logic do_write;
  logic do_read;

  // Store data bits above the widest latch are deliberately dropped.
  logic unused_bits;
  assign unused_bits = &{1'b0, wdata[WORD_SIZE-1:16]};

  assign raw_all = {switch_raw, key_raw};

  genvar gi;
  generate
    for (gi = 0; gi < NBITS; gi++) begin : g_db
      logic             sync1_reg;
      logic             sync2_reg;
      logic             stable_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_reg  <= IDLE_VAL[gi];
          sync2_reg  <= IDLE_VAL[gi];
          stable_reg <= IDLE_VAL[gi];
          cnt_reg    <= '0;
        end else begin
          sync1_reg <= raw_all[gi];
          sync2_reg <= sync1_reg;
          // Any return to the stable level restarts the qualification run.
          if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_MAX) begin
            stable_reg <= sync2_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign stable_all[gi] = stable_reg;
      assign adopt[gi]      = (sync2_reg != stable_reg) && (cnt_reg == CNT_MAX);
    end

    // A press is the stable level about to fall from 1 to 0.
    for (gi = 0; gi < 4; gi++) begin : g_press
      assign press[gi] = adopt[gi] & stable_all[gi];
    end
  endgenerate

  assign in_win   = ((addr & ~WIN_MASK) == WIN_BASE);
  assign do_write = in_win & wr_en;
  // A simultaneous store takes priority; the load half is dropped.
  assign do_read  = in_win & rd_en & ~wr_en;

  always_comb begin
    rd_value = '0;
    case (addr)
      ADDR_HEX:     rd_value = WORD_SIZE'(hex_reg);
      ADDR_LEDR:    rd_value = WORD_SIZE'(ledr_reg);
      ADDR_LEDG:    rd_value = WORD_SIZE'(ledg_reg);
      ADDR_KEY:     rd_value = WORD_SIZE'(stable_all[3:0]);
      ADDR_KEYEDGE: rd_value = WORD_SIZE'(keyedge_reg);
      ADDR_SWITCH:  rd_value = WORD_SIZE'(stable_all[13:4]);
      default:      rd_value = '0;
    endcase
  end

  // Clear sources are applied before new presses so a press landing in the
  // clearing cycle survives; the read still returns the pre-clear flags.
  always_comb begin
    keyedge_clr = 4'b0000;
    if (do_write && (addr == ADDR_KEYEDGE)) begin
      keyedge_clr = wdata[3:0];
    end
    if (do_read && (addr == ADDR_KEYEDGE)) begin
      keyedge_clr = 4'b1111;
    end
    keyedge_next = (keyedge_reg & ~keyedge_clr) | press;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_reg     <= '0;
      ledr_reg    <= '0;
      ledg_reg    <= '0;
      keyedge_reg <= '0;
      rdata_reg   <= '0;
      ack_reg     <= 1'b0;
    end else begin
      if (do_write) begin
        case (addr)
          ADDR_HEX:  hex_reg  <= wdata[15:0];
          ADDR_LEDR: ledr_reg <= wdata[9:0];
          ADDR_LEDG: ledg_reg <= wdata[7:0];
          default:   ;
        endcase
      end
      keyedge_reg <= keyedge_next;
      if (do_read) begin
        rdata_reg <= rd_value;
      end
      ack_reg <= in_win & (wr_en | rd_en);
    end
  end

  assign hex_out = hex_reg;
  assign ledr    = ledr_reg;
  assign ledg    = ledg_reg;
  assign rdata   = rdata_reg;
  assign ack     = ack_reg;

endmodule

// File: doc/niu32_io_responder.md
Name: niu32_io_responder

Overview:
Memory-mapped I/O responder for the Niu32 data-memory port. It answers CPU loads and stores in the I/O window 0xFFFF0000–0xFFFF01FF and owns all board-facing registers. It debounces and synchronizes KEY and SWITCH, captures sticky key-press events, and holds the HEX, LEDR and LEDG output latches. Addresses outside the window are never acknowledged, so the CPU's data RAM services them.

Parameters:
WORD_SIZE, 32, data/address width
DEBOUNCE_CYCLES, 50000, consecutive synchronized samples needed to adopt a new input level (1 ms at 50 MHz; bench uses 4)
ADDR_HEX, 32'hFFFF0000, HEX latch (R/W)
ADDR_LEDR, 32'hFFFF0020, red LED latch (R/W)
ADDR_LEDG, 32'hFFFF0040, green LED latch (R/W)
ADDR_KEY, 32'hFFFF0100, debounced KEY level (RO)
ADDR_KEYEDGE, 32'hFFFF0104, sticky key-press flags (read-to-clear, W1C)
ADDR_SWITCH, 32'hFFFF0120, debounced SWITCH level (RO)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
addr  in  WORD_SIZE  byte address from the CPU (MAR)
wdata  in  WORD_SIZE  store data
wr_en  in  1  store request, one cycle
rd_en  in  1  load request, one cycle
rdata  out  WORD_SIZE  load data, registered
ack  out  1  one-cycle pulse: access completed, address in window
key_raw  in  4  board KEY, active-low, asynchronous
switch_raw  in  10  board SWITCH, asynchronous
hex_out  out  16  four hex digits to the seven-segment decoders
ledr  out  10  red LEDs
ledg  out  8  green LEDs

Behaviour:
- Reset (async, immediate): hex_out=0, ledr=0, ledg=0, rdata=0, ack=0, edge flags=0. KEY sync/stable regs=4'b1111 (released). SWITCH sync/stable regs=0. Debounce counters=0. Any in-flight ack is dropped.
- In-window decode is combinational on addr. Any address in 0xFFFF0000–0xFFFF01FF is in the window, including unmapped holes.
- Store (wr_en=1, in window): the target register updates at that clk edge. ack=1 in the next cycle.
  - HEX takes wdata[15:0], LEDR takes wdata[9:0], LEDG takes wdata[7:0].
  - KEYEDGE: clears each flag whose wdata bit is 1.
  - KEY, SWITCH and holes: data ignored, still acked.
- Load (rd_en=1, in window): rdata is loaded at that edge and ack=1 in the next cycle. rdata holds until the next load.
  - Values are zero-extended: {16'b0,hex_out}, {22'b0,ledr}, {24'b0,ledg}, {28'b0,key_stable} (active-low, raw polarity), {28'b0,edge}, {22'b0,switch_stable}.
  - Holes read 0.
- wr_en and rd_en both high: the store executes, the read is ignored, and a single ack is issued.
- Out of window: no register change, rdata unchanged, ack=0.
- Synchronizer: 2 flops per input bit.
- Debounce, per bit:
  - If sync==stable, counter=0.
  - Otherwise counter increments; on reaching DEBOUNCE_CYCLES-1 it sets stable<=sync and counter<=0.
  - A bounce back to the stable value before that clears the counter.
  - Counter width is clog2(DEBOUNCE_CYCLES).
  - Latency from a clean raw change to the stable update is DEBOUNCE_CYCLES+2 edges.
- Edge flags: edge[i] sets on the key_stable[i] 1→0 transition (press). Release does not set a flag.
- Read of KEYEDGE clears the flags returned. A press detected in the same cycle as the clearing read or W1C write wins: the flag stays 1, and the read returns the pre-clear value.

Test Plan:
- Reset → hex_out=0, ledr=0, ledg=0, ack=0. Read ADDR_KEY with keys released → rdata=0x0000000F, ack one cycle after rd_en.
- Store 0xFFFFABCD to ADDR_HEX, 0x3FF to ADDR_LEDR, 0x1A5 to ADDR_LEDG → hex_out=0xABCD, ledr=0x3FF, ledg=0xA5. Reading ADDR_LEDG back → 0x000000A5.
- DEBOUNCE_CYCLES=4: switch_raw[3] high for 3 cycles then low → SWITCH reads 0. Held high for 6 cycles → reads 0x8 exactly 6 edges after the change.
- key_raw[1] pressed cleanly → read KEYEDGE=0x2, second read=0x0. A press on key 0 landing in the clearing-read cycle → that read returns 0x2, next read 0x1.
- Store/load to 0x00000040 and 0xFFFF0200 → ack stays 0 and no output changes. Load from hole 0xFFFF0080 → ack=1, rdata=0.
- Assert reset in the cycle after rd_en to ADDR_SWITCH → ack never pulses, rdata=0, and outputs clear without waiting for clk.
